// File: rtl/score_display.sv
// Four-digit seven-segment scanner showing a 0..99 score as BCD, a source tag or
// prompt glyph on the leftmost digit, and an optional game-over blink.
module score_display #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] points,
    input  logic [6:0] points2,
    input  logic [6:0] hs,
    input  logic [2:0] letter,
    input  logic       flash,
    input  logic [1:0] disp_sel,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_DIV - 1);

    typedef enum logic {IDLE, CONV} conv_state_e;

    logic [RW-1:0] refresh_cnt_q, refresh_cnt_d;
    logic [1:0]    digit_idx_q, digit_idx_d;
    logic          refresh_wrap;
    logic          capture;
    logic [6:0]    src_value;
    logic [6:0]    sat_value;
    conv_state_e   state_q, state_d;
    logic [6:0]    rem_q, rem_d;
    logic [3:0]    tens_work_q, tens_work_d;
    logic [3:0]    tens_q, tens_d;
    logic [3:0]    ones_q, ones_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_phase_q, blink_phase_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;

    function automatic logic [6:0] digit_glyph(input logic [3:0] d);
        case (d)
            4'd0:    digit_glyph = 7'h40;
            4'd1:    digit_glyph = 7'h79;
            4'd2:    digit_glyph = 7'h24;
            4'd3:    digit_glyph = 7'h30;
            4'd4:    digit_glyph = 7'h19;
            4'd5:    digit_glyph = 7'h12;
            4'd6:    digit_glyph = 7'h02;
            4'd7:    digit_glyph = 7'h78;
            4'd8:    digit_glyph = 7'h00;
            4'd9:    digit_glyph = 7'h10;
            default: digit_glyph = 7'h7F;
        endcase
    endfunction

    // A capture happens exactly when the scan rolls from the leftmost digit back to digit 0.
    always_comb begin
        refresh_wrap  = (refresh_cnt_q == REFRESH_LAST);
        refresh_cnt_d = refresh_wrap ? '0 : refresh_cnt_q + RW'(1);
        digit_idx_d   = refresh_wrap ? digit_idx_q + 2'd1 : digit_idx_q;
        capture       = refresh_wrap && (digit_idx_q == 2'd3);
    end

    always_comb begin
        case (disp_sel)
            2'd1:    src_value = points2;
            2'd2:    src_value = hs;
            default: src_value = points;
        endcase
        sat_value = (src_value > 7'd99) ? 7'd99 : src_value;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (capture) state_d = CONV;
            CONV:    if (rem_q < 7'd10) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Repeated subtraction keeps tens/ones untouched until the final cycle, so no partial value shows.
    always_comb begin
        rem_d       = rem_q;
        tens_work_d = tens_work_q;
        tens_d      = tens_q;
        ones_d      = ones_q;
        case (state_q)
            IDLE: begin
                if (capture) begin
                    rem_d       = sat_value;
                    tens_work_d = '0;
                end
            end
            CONV: begin
                if (rem_q >= 7'd10) begin
                    rem_d       = rem_q - 7'd10;
                    tens_work_d = tens_work_q + 4'd1;
                end else begin
                    tens_d = tens_work_q;
                    ones_d = rem_q[3:0];
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        blink_cnt_d   = '0;
        blink_phase_d = 1'b0;
        if (flash) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d   = blink_cnt_q + BW'(1);
                blink_phase_d = blink_phase_q;
            end
        end
    end

    // Gating the blank with live flash lets the display go steady on the very next update.
    always_comb begin
        an_d  = 4'b1111;
        seg_d = 7'h7F;
        if (!(flash && blink_phase_q)) an_d[digit_idx_q] = 1'b0;
        case (digit_idx_q)
            2'd0: seg_d = digit_glyph(ones_q);
            2'd1: seg_d = (tens_q == 4'd0) ? 7'h7F : digit_glyph(tens_q);
            2'd2: seg_d = 7'h7F;
            default: begin
                case (letter)
                    3'd1: seg_d = 7'h47;
                    3'd2: seg_d = 7'h41;
                    3'd3: seg_d = 7'h46;
                    3'd4: seg_d = 7'h21;
                    default: begin
                        case (disp_sel)
                            2'd1:    seg_d = 7'h2F;
                            2'd2:    seg_d = 7'h09;
                            default: seg_d = 7'h0C;
                        endcase
                    end
                endcase
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            refresh_cnt_q <= '0;
            digit_idx_q   <= 2'd0;
            rem_q         <= '0;
            tens_work_q   <= '0;
            tens_q        <= '0;
            ones_q        <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            an_q          <= 4'b1111;
            seg_q         <= 7'h7F;
        end else begin
            refresh_cnt_q <= refresh_cnt_d;
            digit_idx_q   <= digit_idx_d;
            rem_q         <= rem_d;
            tens_work_q   <= tens_work_d;
            tens_q        <= tens_d;
            ones_q        <= ones_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = 1'b1;

endmodule

// File: tb/tb_score_display.sv
// Directed scoreboard bench for score_display with a short refresh and blink period;
// expected anode/segment values are queued with the cycle at which they must appear.
module tb_score_display;

    localparam int REFRESH_DIV = 16;
    localparam int BLINK_DIV   = 8;

    localparam logic [6:0] G0 = 7'h40, G1 = 7'h79, G2 = 7'h24, G4 = 7'h19, G5 = 7'h12;
    localparam logic [6:0] G7 = 7'h78, G8 = 7'h00, G9 = 7'h10, GBL = 7'h7F;
    localparam logic [6:0] GP = 7'h0C, GR = 7'h2F, GH = 7'h09, GC = 7'h46;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] points = '0, points2 = '0, hs = '0;
    logic [2:0] letter = '0;
    logic       flash = 1'b0;
    logic [1:0] disp_sel = '0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int          q_at[$];
    logic [11:0] q_exp[$];
    string       q_tag[$];
    string       m_tag;
    logic [11:0] m_exp;

    score_display #(
        .REFRESH_DIV(REFRESH_DIV),
        .BLINK_DIV  (BLINK_DIV)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .points  (points),
        .points2 (points2),
        .hs      (hs),
        .letter  (letter),
        .flash   (flash),
        .disp_sel(disp_sel),
        .an      (an),
        .seg     (seg),
        .dp      (dp)
    );

    always #5 clk = ~clk;

    // cyc counts rising edges since rst_n was released.
    always @(posedge clk) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check_val(input string tag, input logic [6:0] obs, input logic [6:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic push(input string tag, input int at, input logic [3:0] an_e,
                        input logic [6:0] seg_e, input bit chk_seg);
        int i;
        i = 0;
        while (i < q_at.size() && q_at[i] <= at) i++;
        q_at.insert(i, at);
        q_exp.insert(i, {chk_seg, an_e, seg_e});
        q_tag.insert(i, tag);
    endtask

    task automatic push_slot(input string tag, input int scan, input int idx, input logic [6:0] seg_e);
        logic [3:0] a;
        a = 4'b0001 << idx;
        push(tag, 64 * scan + 16 * idx + 14, ~a, seg_e, 1'b1);
    endtask

    always @(negedge clk) begin
        while (rst_n && q_at.size() > 0 && q_at[0] <= cyc) begin
            m_tag = q_tag.pop_front();
            m_exp = q_exp.pop_front();
            void'(q_at.pop_front());
            check_val({m_tag, "_an"}, {3'b000, an}, {3'b000, m_exp[10:7]});
            if (m_exp[11]) check_val({m_tag, "_seg"}, seg, m_exp[6:0]);
        end
    end

    task automatic wait_cyc(input int n);
        int guard;
        guard = 0;
        while (cyc < n && guard < n + 1000) begin
            @(negedge clk);
            guard++;
        end
        check_val("wait_cyc_reached", 7'(cyc >= n), 7'd1);
    endtask

    task automatic drain(input string tag);
        int guard;
        guard = 0;
        while (q_at.size() > 0 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        check_val({tag, "_drain_left"}, 7'(q_at.size()), 7'd0);
        q_at.delete();
        q_exp.delete();
        q_tag.delete();
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_val({tag, "_rst_an"}, {3'b000, an}, 7'h0F);
        check_val({tag, "_rst_seg"}, seg, GBL);
        check_val({tag, "_rst_dp"}, {6'd0, dp}, 7'd1);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Steady scan of 47 from points; scan 0 still shows the post-reset 0.
        points = 7'd47; disp_sel = 2'd0; letter = 3'd0; flash = 1'b0;
        do_reset("A");
        push_slot("A_s0_d0", 0, 0, G0);
        push_slot("A_s0_d1", 0, 1, GBL);
        push_slot("A_s0_d2", 0, 2, GBL);
        push_slot("A_s0_d3", 0, 3, GP);
        for (int s = 1; s < 8; s++) begin
            push_slot($sformatf("A_s%0d_d0", s), s, 0, G7);
            push_slot($sformatf("A_s%0d_d1", s), s, 1, G4);
            push_slot($sformatf("A_s%0d_d2", s), s, 2, GBL);
            push_slot($sformatf("A_s%0d_d3", s), s, 3, GP);
        end
        push("A_slot_first", 65, 4'b1110, G7, 1'b0);
        push("A_slot_last", 80, 4'b1110, G7, 1'b0);
        push("A_slot_next", 81, 4'b1101, G4, 1'b1);
        drain("A");

        // High score 5, then a saturating points2 with a live tag switch mid-slot.
        points = 7'd47; points2 = 7'd0; hs = 7'd5; disp_sel = 2'd2;
        do_reset("B");
        push_slot("B_hs_d0", 1, 0, G5);
        push_slot("B_hs_d1", 1, 1, GBL);
        push_slot("B_hs_d2", 1, 2, GBL);
        push("B_tag_H", 114, 4'b0111, GH, 1'b1);
        push("B_tag_r_live", 116, 4'b0111, GR, 1'b1);
        push_slot("B_sat_d0", 2, 0, G9);
        push_slot("B_sat_d1", 2, 1, G9);
        push_slot("B_sat_d3", 2, 3, GR);
        wait_cyc(115);
        points2 = 7'd120; disp_sel = 2'd1;
        drain("B");

        // Prompt glyph C, then an out-of-range letter falls back to the source tag.
        points = 7'd47; disp_sel = 2'd0; letter = 3'd3;
        do_reset("C");
        push("C_glyph_first", 49, 4'b0111, GC, 1'b1);
        push_slot("C_glyph", 0, 3, GC);
        push_slot("C_s1_d0", 1, 0, G7);
        push_slot("C_tag_back", 1, 3, GP);
        wait_cyc(70);
        letter = 3'd6;
        drain("C");

        // Blink: 8 visible, 8 dark, then flash low restores the display immediately.
        points = 7'd47; disp_sel = 2'd0; letter = 3'd0; flash = 1'b0;
        do_reset("D");
        push("D_vis_end", 108, 4'b1011, GBL, 1'b1);
        push("D_dark_start", 109, 4'b1111, GBL, 1'b0);
        push("D_dark_end", 116, 4'b1111, GBL, 1'b0);
        push("D_vis2_start", 117, 4'b0111, GP, 1'b1);
        push("D_vis2_end", 124, 4'b0111, GP, 1'b1);
        push("D_dark2_start", 125, 4'b1111, GBL, 1'b0);
        push("D_steady", 131, 4'b1110, G7, 1'b1);
        push("D_steady2", 140, 4'b1110, G7, 1'b1);
        push("D_steady3", 158, 4'b1101, G4, 1'b1);
        wait_cyc(100);
        flash = 1'b1;
        wait_cyc(130);
        flash = 1'b0;
        drain("D");

        // Reset on the fifth clock of converting 98 aborts it; 98 appears only after a new capture.
        points = 7'd98; disp_sel = 2'd0;
        do_reset("E");
        wait_cyc(68);
        rst_n = 1'b0;
        @(negedge clk);
        check_val("E_midconv_an", {3'b000, an}, 7'h0F);
        check_val("E_midconv_seg", seg, GBL);
        rst_n = 1'b1;
        push_slot("E_s0_d0", 0, 0, G0);
        push_slot("E_s0_d1", 0, 1, GBL);
        push("E_pre_update", 65, 4'b1110, G0, 1'b1);
        push_slot("E_s1_d0", 1, 0, G8);
        push_slot("E_s1_d1", 1, 1, G9);
        drain("E");

        // Points change mid-scan: 47 held until the next capture, then 12.
        points = 7'd47; disp_sel = 2'd0;
        do_reset("F");
        push_slot("F_s1_d0", 1, 0, G7);
        push_slot("F_s1_d1", 1, 1, G4);
        push("F_hold", 129, 4'b1110, G7, 1'b1);
        push("F_new_d0", 140, 4'b1110, G2, 1'b1);
        push_slot("F_new_d1", 2, 1, G1);
        wait_cyc(70);
        points = 7'd12;
        drain("F");

        // Boundaries: 10 and 9 around the tens threshold, disp_sel=3 acting as points.
        points = 7'd10; points2 = 7'd55; hs = 7'd77; disp_sel = 2'd3;
        do_reset("G");
        push_slot("G_10_d0", 1, 0, G0);
        push_slot("G_10_d1", 1, 1, G1);
        push_slot("G_sel3_tag", 1, 3, GP);
        push_slot("G_9_d0", 2, 0, G9);
        push_slot("G_9_d1", 2, 1, GBL);
        wait_cyc(70);
        points = 7'd9;
        drain("G");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/score_display.md
SCORE_DISPLAY -- requirements
Module: score_display

Interface
REQ-001 The module SHALL have parameter REFRESH_DIV, default 100000, giving the clk cycles per digit slot; legal values are 16 or more.
REQ-002 The module SHALL have parameter BLINK_DIV, default 25000000, giving the clk cycles per blink half-period.
REQ-003 clk  in  1  system clock; the block has one clock, and every register updates on the rising edge.
REQ-004 rst_n  in  1  reset; synchronous and active-low.
REQ-005 points  in  7  current-run score, binary.
REQ-006 points2  in  7  last-run score, binary.
REQ-007 hs  in  7  high score, binary.
REQ-008 letter  in  3  prompt code: 1=L, 2=U, 3=C, 4=d; 0 and 5-7 mean no prompt.
REQ-009 flash  in  1  game-over indication; the display blinks while it is high.
REQ-010 disp_sel  in  2  source select: 0=points, 1=points2, 2=hs, 3 is treated as 0.
REQ-011 an  out  4  digit anodes, active-low; an[0] is the rightmost digit.
REQ-012 seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-013 dp  out  1  decimal point, active-low; tied to 1 (off).

Function
REQ-014 Refresh counter: counts 0..REFRESH_DIV-1 and then wraps to 0. On each wrap, the 2-bit digit index advances 0->1->2->3->0.
REQ-015 Capture: when the digit index moves 3->0, the selected source SHALL be latched.
- Values above 99 saturate to 99.
- The capture starts a BCD conversion.
REQ-016 Converter FSM, states IDLE/CONV.
- IDLE->CONV on capture: tens=0, rem=value.
- In CONV, each cycle with rem>=10: rem-=10, tens+=1.
- When rem<10: write tens and ones (ones=rem) to the display registers, then return to IDLE.
- Latency from capture to update is at most 11 cycles.
REQ-017 The display registers SHALL hold their previous value until a conversion completes; no partial value is ever shown.
REQ-018 If a capture arrives while the FSM is in CONV, it SHALL be ignored.
REQ-019 Digit contents:
- an[0]: ones digit.
- an[1]: tens digit; blank if tens=0.
- an[2]: always blank.
- an[3]: the prompt glyph if letter is 1-4; otherwise the source tag (P=points, r=points2, H=hs).
REQ-020 letter and disp_sel, as used for the an[3] glyph, SHALL be sampled live each cycle and SHALL NOT wait for a capture.
REQ-021 Glyph codes (hex, seg[6:0]):
- Digits: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
- Other glyphs: blank=7F, P=0C, r=2F, H=09, L=47, U=41, C=46, d=21.
REQ-022 an and seg SHALL be registered. Exactly one anode is low, matching the digit index, and both outputs update one cycle after the index changes.
REQ-023 Blink while flash=1:
- A blink counter counts 0..BLINK_DIV-1.
- The blink phase toggles on each wrap.
- While phase=1, an=1111 and seg is don't-care.
REQ-024 Blink while flash=0: the blink counter and phase are held at 0, so the display is steady.
REQ-025 A rising edge of flash SHALL start with phase 0 (visible) for a full BLINK_DIV.
REQ-026 Source or letter changes mid-scan SHALL take effect as follows:
- Numeric digits change only at the next capture.
- The an[3] glyph changes in the next registered update.

Reset
REQ-027 While rst_n=0 at a clk edge, the following SHALL apply on the next cycle:
- refresh counter=0, digit index=0;
- tens=ones=0;
- FSM=IDLE, and any in-progress conversion is aborted;
- blink counter=0, phase=0;
- an=1111, seg=7F, dp=1.
REQ-028 After rst_n returns high, scanning SHALL begin at digit 0. The displayed value is 0, with the tens digit blank, until the first capture (the first 3->0 index move) has completed conversion.

Verification (REFRESH_DIV=16, BLINK_DIV=8)
REQ-029 Scenario: disp_sel=0, points=47, reset, run 8 full scans.
- Per slot, expect an0 seg=78 (7) and an1 seg=19 (4).
- Expect an2 seg=7F and an3 seg=0C (P).
- Each anode is low for 16 cycles.
REQ-030 Scenario: hs=5, disp_sel=2.
- Expect an1 blank (7F), an0 seg=12 (5), an3 seg=09 (H).
- Setting points2=120 with disp_sel=1 shows 99 (both digits seg=10) and an3 seg=2F.
REQ-031 Scenario: letter=3, then letter=6.
- With letter=3, an3 seg=46 (C) within 1 cycle of its slot.
- With letter=6, an3 reverts to the source tag.
REQ-032 Scenario: flash rises.
- an is visible for 8 cycles, then 1111 for 8, alternating.
- flash low makes the display steady within 1 cycle.
REQ-033 Scenario: reset at clock 5 of a CONV from value 98 -> an=1111, seg=7F; afterwards the display shows 0 until the next capture completes, then 98.
REQ-034 Scenario: change points 47->12 mid-scan -> digits keep showing 47 until the next 3->0 capture; 12 appears at most 11 cycles later.
